// File: rtl/uart_rx_mon.sv
`timescale 1ns / 1ps
// uart_rx_mon: UART receive monitor with 16x oversampling, optional parity,
// 1 or 2 checked stop bits and a show-ahead receive FIFO.
//
// Ports:
//   clk, rst_b          clock (rising edge), asynchronous active-low reset
//   baud_div            oversample tick period minus 1, in clk cycles
//   sin                 asynchronous serial line, idle high
//   err_clr             one-cycle pulse clearing the sticky overflow flag
//   rx_data/perr/ferr   FIFO head entry, zero while the FIFO is empty
//   rx_valid, rx_ready  drain handshake; pop on rx_valid && rx_ready
//   fifo_count          number of stored entries
//   overflow            sticky: a character was dropped on a full FIFO
module uart_rx_mon #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          sin,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_BITS + 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop,
    StPush,
    StBreak
  } state_e;

  // Oversample tick generator; baud_div is only sampled on reload.
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  assign tick  = (div_q == '0);
  assign div_d = tick ? baud_div : div_q - DIV_W'(1);

  // Line synchroniser; prev flop runs at tick rate so edges are seen per tick.
  logic sin_m_q, s_sin_q, prev_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      div_q   <= '0;
      sin_m_q <= 1'b1;
      s_sin_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      div_q   <= div_d;
      sin_m_q <= sin;
      s_sin_q <= sin_m_q;
      if (tick) prev_q <= s_sin_q;
    end
  end

  // Receive FSM
  state_e               state_q, state_d;
  logic [3:0]           tcnt_q, tcnt_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 bit_mid;
  logic                 push_req;

  // DATA/PAR/STOP sample once per 16 ticks, counter wraps naturally.
  assign bit_mid  = tick && (tcnt_q == 4'd15);
  assign push_req = (state_q == StPush);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      StIdle: begin
        if (tick && prev_q && !s_sin_q) begin
          state_d = StStart;
          tcnt_d  = 4'd0;
        end
      end
      StStart: begin
        if (tick) begin
          if (tcnt_q == 4'd7) begin
            if (s_sin_q) begin
              state_d = StIdle;  // glitch, not a real start bit
            end else begin
              state_d = StData;
              tcnt_d  = 4'd0;
              bcnt_d  = 4'd0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) tcnt_d = tcnt_q + 4'd1;
        if (bit_mid) begin
          shift_d = {s_sin_q, shift_q[DATA_BITS-1:1]};
          if (bcnt_q == 4'(DATA_BITS - 1)) begin
            bcnt_d  = 4'd0;
            state_d = (PARITY != 0) ? StPar : StStop;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
      end
      StPar: begin
        if (tick) tcnt_d = tcnt_q + 4'd1;
        if (bit_mid) begin
          perr_d  = s_sin_q ^ ((PARITY == 1) ? ^shift_q : ~^shift_q);
          state_d = StStop;
        end
      end
      StStop: begin
        if (tick) tcnt_d = tcnt_q + 4'd1;
        if (bit_mid) begin
          if (!s_sin_q) ferr_d = 1'b1;
          if (bcnt_q == 4'(STOP_BITS - 1)) begin
            state_d = StPush;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
      end
      StPush: begin
        state_d = ferr_q ? StBreak : StIdle;
      end
      StBreak: begin
        // Held-low line (break) must go high before a new start is accepted.
        if (s_sin_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Receive FIFO
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, pop, push_ok;
  logic [EW-1:0] head;

  assign rx_valid = (count_q != '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign pop      = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Set wins over clear.
    overflow_d = (overflow_q && !err_clr) || (push_req && !push_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= {ferr_q, perr_q, shift_q};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Head is gated so stale storage never shows while empty.
  assign head       = rx_valid ? mem_q[rptr_q] : '0;
  assign rx_data    = head[DATA_BITS-1:0];
  assign rx_perr    = head[DATA_BITS];
  assign rx_ferr    = head[DATA_BITS+1];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_mon.sv
`timescale 1ns / 1ps
module tb_uart_rx_mon;

  localparam int unsigned BitClks = 64;  // 16 ticks * (baud_div + 1)

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic        sin_n = 1'b1;
  logic        sin_p = 1'b1;
  logic        err_clr = 1'b0;
  logic        rdy_n = 1'b0;

  logic [7:0] data_n, data_e, data_o;
  logic       perr_n, perr_e, perr_o;
  logic       ferr_n, ferr_e, ferr_o;
  logic       valid_n, valid_e, valid_o;
  logic       ovf_n, ovf_e, ovf_o;
  logic [2:0] cnt_n;
  logic [3:0] cnt_e, cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] q_n[$];
  logic [9:0] q_e[$];
  logic [9:0] q_o[$];
  logic [9:0] exp_n, exp_e, exp_o;

  always #5 clk = ~clk;

  uart_rx_mon #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) u_dut_n (
    .clk(clk), .rst_b(rst_b), .baud_div(baud_div), .sin(sin_n), .err_clr(err_clr),
    .rx_data(data_n), .rx_perr(perr_n), .rx_ferr(ferr_n), .rx_valid(valid_n),
    .rx_ready(rdy_n), .fifo_count(cnt_n), .overflow(ovf_n)
  );

  uart_rx_mon #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8), .DIV_W(16)) u_dut_e (
    .clk(clk), .rst_b(rst_b), .baud_div(baud_div), .sin(sin_p), .err_clr(err_clr),
    .rx_data(data_e), .rx_perr(perr_e), .rx_ferr(ferr_e), .rx_valid(valid_e),
    .rx_ready(1'b1), .fifo_count(cnt_e), .overflow(ovf_e)
  );

  uart_rx_mon #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8), .DIV_W(16)) u_dut_o (
    .clk(clk), .rst_b(rst_b), .baud_div(baud_div), .sin(sin_p), .err_clr(err_clr),
    .rx_data(data_o), .rx_perr(perr_o), .rx_ferr(ferr_o), .rx_valid(valid_o),
    .rx_ready(1'b1), .fifo_count(cnt_o), .overflow(ovf_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop side: compare every accepted head entry.
  always @(negedge clk) begin
    if (rst_b && valid_n && rdy_n) begin
      if (q_n.size() == 0) begin
        check_eq("n_spurious", 32'(q_n.size()), 32'd1);
      end else begin
        exp_n = q_n.pop_front();
        check_eq("n_entry", 32'({ferr_n, perr_n, data_n}), 32'(exp_n));
      end
    end
    if (rst_b && valid_e) begin
      if (q_e.size() == 0) begin
        check_eq("e_spurious", 32'(q_e.size()), 32'd1);
      end else begin
        exp_e = q_e.pop_front();
        check_eq("e_entry", 32'({ferr_e, perr_e, data_e}), 32'(exp_e));
      end
    end
    if (rst_b && valid_o) begin
      if (q_o.size() == 0) begin
        check_eq("o_spurious", 32'(q_o.size()), 32'd1);
      end else begin
        exp_o = q_o.pop_front();
        check_eq("o_entry", 32'({ferr_o, perr_o, data_o}), 32'(exp_o));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit par_line, input logic b);
    if (par_line) sin_p = b;
    else sin_n = b;
    cycles(BitClks);
  endtask

  task automatic send(input bit par_line, input logic [7:0] d, input bit has_par,
                      input logic pbit, input logic stop);
    drive_bit(par_line, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(par_line, d[i]);
    if (has_par) drive_bit(par_line, pbit);
    drive_bit(par_line, stop);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((q_n.size() != 0 || valid_n) && k < 4000) begin
      cycles(1);
      k++;
    end
    check_eq(tag, 32'(q_n.size()), 32'd0);
    check_eq({tag, "_valid"}, 32'(valid_n), 32'd0);
  endtask

  initial begin
    bit found;

    // Reset state
    cycles(5);
    check_eq("rst_valid", 32'(valid_n), 32'd0);
    check_eq("rst_data", 32'(data_n), 32'd0);
    check_eq("rst_count", 32'(cnt_n), 32'd0);
    check_eq("rst_ovf", 32'(ovf_n), 32'd0);
    rst_b = 1'b1;
    cycles(20);

    // Basic 8N1, back-to-back
    q_n.push_back(10'h055);
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    q_n.push_back(10'h0A3);
    send(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1);
    cycles(10);
    check_eq("basic_count", 32'(cnt_n), 32'd2);
    check_eq("basic_valid", 32'(valid_n), 32'd1);
    check_eq("basic_ovf", 32'(ovf_n), 32'd0);
    rdy_n = 1'b1;
    wait_drain("basic_drain");
    rdy_n = 1'b0;

    // Parity: even and odd receivers share one line
    q_e.push_back({2'b00, 8'h07});
    q_o.push_back({2'b01, 8'h07});
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    q_e.push_back({2'b01, 8'h07});
    q_o.push_back({2'b00, 8'h07});
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    cycles(200);
    check_eq("par_e_done", 32'(q_e.size()), 32'd0);
    check_eq("par_o_done", 32'(q_o.size()), 32'd0);

    // Framing error, line held low afterwards must not retrigger
    q_n.push_back({2'b10, 8'h41});
    send(1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
    cycles(5 * BitClks);
    check_eq("ferr_break_count", 32'(cnt_n), 32'd1);
    sin_n = 1'b1;
    cycles(2 * BitClks);
    check_eq("ferr_idle_count", 32'(cnt_n), 32'd1);
    // 3-tick glitch on idle line
    sin_n = 1'b0;
    cycles(12);
    sin_n = 1'b1;
    cycles(3 * BitClks);
    check_eq("glitch_count", 32'(cnt_n), 32'd1);
    rdy_n = 1'b1;
    wait_drain("ferr_drain");
    rdy_n = 1'b0;

    // Overflow on a 4-deep FIFO
    for (int c = 8'h31; c <= 8'h35; c++) begin
      if (c <= 8'h34) q_n.push_back({2'b00, 8'(c)});
      send(1'b0, 8'(c), 1'b0, 1'b0, 1'b1);
    end
    cycles(10);
    check_eq("ovf_count", 32'(cnt_n), 32'd4);
    check_eq("ovf_set", 32'(ovf_n), 32'd1);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    cycles(1);
    check_eq("ovf_clr", 32'(ovf_n), 32'd0);

    // Full FIFO: pop in the same cycle as the push of 0x36
    q_n.push_back(10'h036);
    found = 1'b0;
    fork
      send(1'b0, 8'h36, 1'b0, 1'b0, 1'b1);
      begin
        for (int k = 0; k < 2000 && !found; k++) begin
          cycles(1);
          if (u_dut_n.push_req) begin
            found = 1'b1;
            rdy_n = 1'b1;
            cycles(1);
            rdy_n = 1'b0;
          end
        end
      end
    join
    check_eq("fullpp_seen", 32'(found), 32'd1);
    check_eq("fullpp_count", 32'(cnt_n), 32'd4);
    check_eq("fullpp_ovf", 32'(ovf_n), 32'd0);
    rdy_n = 1'b1;
    wait_drain("fullpp_drain");
    rdy_n = 1'b0;

    // Reset in the middle of 0x5A with one entry stored
    q_n.push_back(10'h011);
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    cycles(10);
    check_eq("pre_rst_count", 32'(cnt_n), 32'd1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    cycles(20);
    rst_b = 1'b0;
    q_n.delete();
    cycles(3);
    check_eq("mid_rst_valid", 32'(valid_n), 32'd0);
    check_eq("mid_rst_data", 32'(data_n), 32'd0);
    check_eq("mid_rst_count", 32'(cnt_n), 32'd0);
    check_eq("mid_rst_ovf", 32'(ovf_n), 32'd0);
    sin_n = 1'b1;
    cycles(2);
    rst_b = 1'b1;
    cycles(2 * BitClks);
    q_n.push_back(10'h066);
    send(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
    cycles(10);
    check_eq("post_rst_count", 32'(cnt_n), 32'd1);
    rdy_n = 1'b1;
    wait_drain("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
